// File: rtl/paged_pkg.sv
// Shared types and constants for the paged cache controller: fs file selectors,
// permission bit layout, miss-engine states and per-slot metadata.
package paged_pkg;

  localparam logic FS_MEM  = 1'b0;
  localparam logic FS_META = 1'b1;

  localparam int META_X    = 0;
  localparam int META_W    = 1;
  localparam int META_R    = 2;
  localparam int META_ELEV = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_MEM,
    ST_WB_META,
    ST_FILL_MEM,
    ST_FILL_META,
    ST_INSTALL
  } cache_state_t;

  typedef struct packed {
    logic       valid;
    logic       dirty;
    logic [3:0] perms;
  } slot_meta_t;

  // Supervisor accesses are never denied; user accesses need the matching permission bits.
  function automatic logic perm_fault(input logic user, input logic we, input logic exec,
                                      input logic [3:0] perms);
    return user && (perms[META_ELEV] ||
                    (!we && !perms[META_R]) ||
                    (!we && exec && !perms[META_X]) ||
                    (we && !perms[META_W]));
  endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// Combinational victim pick: lowest-index invalid slot, otherwise the oldest
// timestamp with ties going to the lowest index.
module lru_victim_sel #(
  parameter int SLOTS_W = 4,
  parameter int TS_W    = 16
) (
  input  logic [(1<<SLOTS_W)-1:0]           valid,
  input  logic [(1<<SLOTS_W)-1:0][TS_W-1:0] ts,
  output logic [SLOTS_W-1:0]                victim
);

  localparam int SLOTS = 1 << SLOTS_W;

  logic            found_free;
  logic [TS_W-1:0] best_ts;

  always_comb begin
    victim     = '0;
    found_free = 1'b0;
    best_ts    = ts[0];
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim     = SLOTS_W'(i);
        found_free = 1'b1;
      end
    end
    if (!found_free) begin
      for (int i = 1; i < SLOTS; i++) begin
        if (ts[i] < best_ts) begin
          victim  = SLOTS_W'(i);
          best_ts = ts[i];
        end
      end
    end
  end

endmodule

// File: rtl/paged_dp_ram.sv
// Two-port word store with registered, read-first reads on both ports.
module paged_dp_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic [DW-1:0] rdata_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (we_b) mem[addr_b] <= wdata_b;
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/paged_cache_ctrl.sv
// Dual-port paged cache: hits complete in one cycle, misses run writeback/fill
// against the fs bridge through a single miss engine that owns RAM port A while busy.
module paged_cache_ctrl
  import paged_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int PAGE_W  = 12,
  parameter int PAGES_W = 4,
  parameter int TS_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_user,
  input  logic              a_exec,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_fault,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_user,
  input  logic              b_exec,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_fault,
  output logic [DATA_W-1:0] b_rdata,
  output logic              fs_req,
  output logic              fs_we,
  output logic              fs_file,
  output logic [ADDR_W-1:0] fs_addr,
  output logic [DATA_W-1:0] fs_wdata,
  input  logic              fs_ready,
  input  logic [DATA_W-1:0] fs_rdata,
  output logic              busy
);

  localparam int SLOTS  = 1 << PAGES_W;
  localparam int TAG_W  = ADDR_W - PAGE_W;
  localparam int RAM_AW = PAGES_W + PAGE_W;

  cache_state_t state_reg, state_next;

  slot_meta_t                  meta_reg [SLOTS];
  logic [TAG_W-1:0]            tag_reg  [SLOTS];
  logic [SLOTS-1:0][TS_W-1:0]  ts_reg;
  logic [TS_W-1:0]             lru_cnt_reg;

  logic [PAGE_W-1:0]  off_reg, off_inc;
  logic [PAGES_W-1:0] victim_reg;
  logic [TAG_W-1:0]   miss_tag_reg, wb_tag_reg;
  logic [3:0]         wb_perms_reg, fill_perms_reg;
  logic a_ack_reg, a_fault_reg, a_rd_ok_reg;
  logic b_ack_reg, b_fault_reg, b_rd_ok_reg;

  logic [SLOTS-1:0]   valid_vec, a_hit_vec, b_hit_vec;
  logic [PAGES_W-1:0] a_slot, b_slot, victim;
  logic [TAG_W-1:0]   a_tag, b_tag, miss_tag_c;
  logic [PAGE_W-1:0]  a_off, b_off;
  logic a_hit, b_hit, a_go, b_go, a_accept, b_accept, a_fault_c, b_fault_c;
  logic a_write_ok, b_write_ok, miss_start, victim_dirty, hit_cycle;

  logic              ram_a_we;
  logic [RAM_AW-1:0] ram_a_addr;
  logic [DATA_W-1:0] ram_a_wdata, ram_qa, ram_qb;

  assign a_tag   = a_addr[ADDR_W-1:PAGE_W];
  assign b_tag   = b_addr[ADDR_W-1:PAGE_W];
  assign a_off   = a_addr[PAGE_W-1:0];
  assign b_off   = b_addr[PAGE_W-1:0];
  assign off_inc = off_reg + PAGE_W'(1);

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_tag_cmp
    assign valid_vec[gi] = meta_reg[gi].valid;
    assign a_hit_vec[gi] = meta_reg[gi].valid && (tag_reg[gi] == a_tag);
    assign b_hit_vec[gi] = meta_reg[gi].valid && (tag_reg[gi] == b_tag);
  end

  always_comb begin
    a_slot = '0;
    b_slot = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (a_hit_vec[i]) a_slot = PAGES_W'(i);
      if (b_hit_vec[i]) b_slot = PAGES_W'(i);
    end
  end

  assign a_hit     = |a_hit_vec;
  assign b_hit     = |b_hit_vec;
  assign a_fault_c = perm_fault(a_user, a_we, a_exec, meta_reg[a_slot].perms);
  assign b_fault_c = perm_fault(b_user, b_we, b_exec, meta_reg[b_slot].perms);

  // A port that was just acked still shows its request for one cycle; skip it.
  assign a_go = a_req && !a_ack_reg && (state_reg == ST_IDLE);
  assign b_go = b_req && !b_ack_reg && (state_reg == ST_IDLE);

  // A miss on A takes priority and stalls B; a B miss waits while A is hitting.
  assign a_accept   = a_go && a_hit;
  assign b_accept   = b_go && b_hit && !(a_go && !a_hit);
  assign miss_start = (a_go && !a_hit) || (!a_go && b_go && !b_hit);
  assign miss_tag_c = (a_go && !a_hit) ? a_tag : b_tag;

  assign a_write_ok = a_accept && a_we && !a_fault_c;
  assign b_write_ok = b_accept && b_we && !b_fault_c && !(a_write_ok && (a_addr == b_addr));
  assign hit_cycle  = (a_accept && !a_fault_c) || (b_accept && !b_fault_c);

  lru_victim_sel #(.SLOTS_W(PAGES_W), .TS_W(TS_W)) u_victim (
    .valid  (valid_vec),
    .ts     (ts_reg),
    .victim (victim)
  );

  assign victim_dirty = meta_reg[victim].valid && meta_reg[victim].dirty;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    fs_req     = 1'b0;
    fs_we      = 1'b0;
    fs_file    = FS_MEM;
    fs_addr    = '0;
    fs_wdata   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (miss_start) state_next = victim_dirty ? ST_WB_MEM : ST_FILL_MEM;
      end
      ST_WB_MEM: begin
        fs_req   = 1'b1;
        fs_we    = 1'b1;
        fs_addr  = {wb_tag_reg, off_reg};
        fs_wdata = ram_qa;
        if (fs_ready && (&off_reg)) state_next = ST_WB_META;
      end
      ST_WB_META: begin
        fs_req   = 1'b1;
        fs_we    = 1'b1;
        fs_file  = FS_META;
        fs_addr  = ADDR_W'(wb_tag_reg);
        fs_wdata = DATA_W'(wb_perms_reg);
        if (fs_ready) state_next = ST_FILL_MEM;
      end
      ST_FILL_MEM: begin
        fs_req  = 1'b1;
        fs_addr = {miss_tag_reg, off_reg};
        if (fs_ready && (&off_reg)) state_next = ST_FILL_META;
      end
      ST_FILL_META: begin
        fs_req  = 1'b1;
        fs_file = FS_META;
        fs_addr = ADDR_W'(miss_tag_reg);
        if (fs_ready) state_next = ST_INSTALL;
      end
      ST_INSTALL: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Writeback reads one word ahead so fs_wdata is already valid when each write starts.
  always_comb begin
    ram_a_we    = a_write_ok;
    ram_a_addr  = {a_slot, a_off};
    ram_a_wdata = a_wdata;
    case (state_reg)
      ST_IDLE:      if (miss_start) ram_a_addr = {victim, {PAGE_W{1'b0}}};
      ST_WB_MEM:    ram_a_addr = {victim_reg, (fs_ready ? off_inc : off_reg)};
      ST_FILL_MEM: begin
        ram_a_we    = fs_ready;
        ram_a_addr  = {victim_reg, off_reg};
        ram_a_wdata = fs_rdata;
      end
      default:      ram_a_we = 1'b0;
    endcase
  end

  paged_dp_ram #(.AW(RAM_AW), .DW(DATA_W)) u_store (
    .clk     (clk),
    .we_a    (ram_a_we),
    .addr_a  (ram_a_addr),
    .wdata_a (ram_a_wdata),
    .rdata_a (ram_qa),
    .we_b    (b_write_ok),
    .addr_b  ({b_slot, b_off}),
    .wdata_b (b_wdata),
    .rdata_b (ram_qb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        meta_reg[i] <= '0;
        tag_reg[i]  <= '0;
        ts_reg[i]   <= '0;
      end
      lru_cnt_reg <= '0;
    end else begin
      if (hit_cycle) begin
        lru_cnt_reg <= lru_cnt_reg + TS_W'(1);
        if (lru_cnt_reg == {TS_W{1'b1}}) begin
          for (int i = 0; i < SLOTS; i++) ts_reg[i] <= '0;
        end else begin
          if (a_accept && !a_fault_c) ts_reg[a_slot] <= lru_cnt_reg;
          if (b_accept && !b_fault_c) ts_reg[b_slot] <= lru_cnt_reg;
        end
      end
      if (a_write_ok) meta_reg[a_slot].dirty <= 1'b1;
      if (b_write_ok) meta_reg[b_slot].dirty <= 1'b1;
      if (miss_start) meta_reg[victim].valid <= 1'b0;
      if (state_reg == ST_INSTALL) begin
        meta_reg[victim_reg] <= '{valid: 1'b1, dirty: 1'b0, perms: fill_perms_reg};
        tag_reg[victim_reg]  <= miss_tag_reg;
        ts_reg[victim_reg]   <= lru_cnt_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      off_reg        <= '0;
      victim_reg     <= '0;
      miss_tag_reg   <= '0;
      wb_tag_reg     <= '0;
      wb_perms_reg   <= '0;
      fill_perms_reg <= '0;
      a_ack_reg      <= 1'b0;
      a_fault_reg    <= 1'b0;
      a_rd_ok_reg    <= 1'b0;
      b_ack_reg      <= 1'b0;
      b_fault_reg    <= 1'b0;
      b_rd_ok_reg    <= 1'b0;
    end else begin
      if (miss_start) begin
        victim_reg   <= victim;
        miss_tag_reg <= miss_tag_c;
        wb_tag_reg   <= tag_reg[victim];
        wb_perms_reg <= meta_reg[victim].perms;
        off_reg      <= '0;
      end
      if (fs_ready && ((state_reg == ST_WB_MEM) || (state_reg == ST_FILL_MEM)))
        off_reg <= off_inc;
      if (fs_ready && (state_reg == ST_FILL_META))
        fill_perms_reg <= fs_rdata[3:0];
      a_ack_reg   <= a_accept;
      a_fault_reg <= a_accept && a_fault_c;
      a_rd_ok_reg <= a_accept && !a_we && !a_fault_c;
      b_ack_reg   <= b_accept;
      b_fault_reg <= b_accept && b_fault_c;
      b_rd_ok_reg <= b_accept && !b_we && !b_fault_c;
    end
  end

  assign a_ack   = a_ack_reg;
  assign a_fault = a_fault_reg;
  assign a_rdata = a_rd_ok_reg ? ram_qa : '0;
  assign b_ack   = b_ack_reg;
  assign b_fault = b_fault_reg;
  assign b_rdata = b_rd_ok_reg ? ram_qb : '0;
  assign busy    = (state_reg != ST_IDLE);

endmodule
